// File: rtl/byte_mem_sequencer.sv
// Byte-RAM initiator: turns one 32-bit CPU load/store (byte/half/word, little-endian)
// into a run of single-byte RAM cycles, assembling and extending load data.
module byte_mem_sequencer #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          wr,
  input  logic [1:0]    size,
  input  logic          uns,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   rdata,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_d,
  output logic          ram_we,
  output logic          ram_sel,
  input  logic [7:0]    ram_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] base;
  logic          wr_q, uns_q;
  logic [1:0]    size_q;
  logic [31:0]   wdata_q;
  logic [1:0]    k, n;
  logic [31:0]   rbuf;
  logic          bad;
  logic          last;
  logic [31:0]   merged;
  logic [31:0]   load_val;

  // Upper address bits are ignored: addresses wrap modulo 2^AW.
  logic unused_addr;
  assign unused_addr = ^addr[31:AW];

  assign bad  = (size == 2'b11) ||
                (size == 2'b01 && addr[0]) ||
                (size == 2'b10 && addr[1:0] != 2'b00);
  assign last = (k == n);
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = bad ? DONE : XFER;
      XFER:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM strobes decode straight from state so a reset kills them without a clock edge.
  always_comb begin
    ram_sel  = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_d    = 8'h00;
    if (state == XFER) begin
      ram_sel  = 1'b1;
      ram_we   = wr_q;
      ram_addr = base + AW'(k);
      ram_d    = wdata_q[{k, 3'b000} +: 8];
    end
  end

  // Final byte arrives combinationally in the last XFER cycle, so merge it before extending.
  always_comb begin
    merged                     = rbuf;
    merged[{k, 3'b000} +: 8]   = ram_q;
    case (size_q)
      2'b00:   load_val = {{24{~uns_q & merged[7]}},  merged[7:0]};
      2'b01:   load_val = {{16{~uns_q & merged[15]}}, merged[15:0]};
      default: load_val = merged;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k     <= 2'd0;
      rdata <= 32'h0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req) begin
            k   <= 2'd0;
            err <= bad;
          end
        end
        XFER: begin
          if (last) begin
            if (!wr_q) rdata <= load_val;
          end else begin
            k <= k + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: request payload and read buffer need no reset; they are always written before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      base    <= addr[AW-1:0];
      wr_q    <= wr;
      uns_q   <= uns;
      size_q  <= size;
      wdata_q <= wdata;
      n       <= (size == 2'b00) ? 2'd0 : (size == 2'b01) ? 2'd1 : 2'd3;
    end
    if (state == XFER && !wr_q) rbuf[{k, 3'b000} +: 8] <= ram_q;
  end

endmodule

// File: tb/tb_byte_mem_sequencer.sv
// Self-checking bench for byte_mem_sequencer: transaction-level model predicts every
// cycle's outputs, directed tests pin RAM contents, latencies and load results.
module tb_byte_mem_sequencer;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst, req, wr, uns;
  logic [1:0]    size;
  logic [31:0]   addr, wdata;
  logic          busy, done, err;
  logic [31:0]   rdata;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_d, ram_q;
  logic          ram_we, ram_sel;

  logic [7:0] mem     [1024];
  logic [7:0] ref_mem [1024];

  int checks = 0;
  int errors = 0;

  byte_mem_sequencer #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we),
    .ram_sel(ram_sel), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we && ram_sel) mem[ram_addr] <= ram_d;
  assign ram_q = mem[ram_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for each cycle of a transaction, queued at accept time.
  typedef struct {
    logic          busy, done, err, sel, we;
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic [31:0]   rdata;
  } cyc_t;

  cyc_t        q[$];
  logic [31:0] exp_rdata = 32'h0;

  task automatic model_accept();
    int            nb;
    logic [AW-1:0] ba;
    logic [31:0]   v;
    cyc_t          c;
    case (size)
      2'b00:   nb = 1;
      2'b01:   nb = 2;
      2'b10:   nb = 4;
      default: nb = 0;
    endcase
    c.busy = 1'b1; c.done = 1'b0; c.err = 1'b0; c.sel = 1'b0; c.we = 1'b0;
    c.a = '0; c.d = 8'h00; c.rdata = exp_rdata;
    if (nb == 0 || (int'(addr[1:0]) % nb) != 0) begin
      c.done = 1'b1; c.err = 1'b1;
      q.push_back(c);
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) begin
        ba = addr[AW-1:0] + AW'(i);
        if (wr) ref_mem[ba] = wdata[8*i +: 8];
        else    v = v | (32'(ref_mem[ba]) << (8*i));
        c.sel = 1'b1; c.we = wr; c.a = ba; c.d = wdata[8*i +: 8];
        q.push_back(c);
      end
      if (!wr) begin
        if (!uns && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        exp_rdata = v;
      end
      c.sel = 1'b0; c.we = 1'b0; c.a = '0; c.d = 8'h00;
      c.done = 1'b1; c.rdata = exp_rdata;
      q.push_back(c);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      exp_rdata = 32'h0;
    end else if (q.size() > 0) begin
      void'(q.pop_front());
    end else if (req) begin
      model_accept();
    end
  end

  always @(negedge clk) begin
    cyc_t e;
    if (q.size() > 0) e = q[0];
    else begin
      e.busy = 1'b0; e.done = 1'b0; e.err = 1'b0; e.sel = 1'b0; e.we = 1'b0;
      e.a = '0; e.d = 8'h00; e.rdata = exp_rdata;
    end
    check("cyc_busy",     32'(busy),     32'(e.busy));
    check("cyc_done",     32'(done),     32'(e.done));
    check("cyc_rdata",    rdata,         e.rdata);
    check("cyc_ram_sel",  32'(ram_sel),  32'(e.sel));
    check("cyc_ram_we",   32'(ram_we),   32'(e.we));
    check("cyc_ram_addr", 32'(ram_addr), 32'(e.a));
    check("cyc_ram_d",    32'(ram_d),    32'(e.d));
    if (e.done) check("cyc_err", 32'(err), 32'(e.err));
  end

  // One request; lat counts sampled cycles from the accept edge up to and including done.
  task automatic do_req(input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic e);
    @(posedge clk); #2;
    req = 1'b1; wr = w; size = s; uns = u; addr = a; wdata = d;
    @(posedge clk); #2;
    req = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h5A5A_5A5A; size = 2'b11; wr = ~w;
    lat = 0;
    e   = 1'bx;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (done) begin
        e = err;
        break;
      end
    end
  endtask

  int   lat, lat2;
  logic e;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; uns = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("reset_busy",   32'(busy),   32'h0);
    check("reset_done",   32'(done),   32'h0);
    check("reset_rdata",  rdata,       32'h0);
    check("reset_ram_we", 32'(ram_we), 32'h0);

    // Word store then load
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hA1B2C3D4, lat, e);
    check("st_word_lat", 32'(lat), 32'd5);
    check("st_word_ram", {mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]}, 32'hA1B2C3D4);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e);
    check("ld_word_lat",   32'(lat), 32'd5);
    check("ld_word_err",   32'(e),   32'h0);
    check("ld_word_rdata", rdata,    32'hA1B2C3D4);

    // Sign/zero extension
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, e);
    check("ld_byte_lat", 32'(lat), 32'd2);
    check("ld_byte_sx",  rdata,    32'hFFFFFFA1);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, e);
    check("ld_byte_zx",  rdata,    32'h000000A1);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, e);
    check("ld_half_lat", 32'(lat), 32'd3);
    check("ld_half_sx",  rdata,    32'hFFFFA1B2);

    // Misaligned / illegal
    do_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, lat, e);
    check("mis_word_lat", 32'(lat), 32'd1);
    check("mis_word_err", 32'(e),   32'h1);
    check("mis_word_hold", rdata,   32'hFFFFA1B2);
    do_req(1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFF_FFFF, lat, e);
    check("mis_half_lat", 32'(lat), 32'd1);
    check("mis_half_err", 32'(e),   32'h1);
    check("mis_half_ram", 32'(mem[16'h13]), 32'hA1);
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, e);
    check("ill_size_lat", 32'(lat), 32'd1);
    check("ill_size_err", 32'(e),   32'h1);
    check("ill_size_hold", rdata,   32'hFFFFA1B2);

    // Busy protocol: req held high through a word store, inputs changed mid-transfer
    @(posedge clk); #2;
    req = 1'b1; wr = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h40; wdata = 32'h55667788;
    @(posedge clk); #2;
    addr = 32'h80; wdata = 32'h0BADF00D;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); lat++;
      if (done) break;
    end
    check("busy_first_lat", 32'(lat), 32'd5);
    @(negedge clk);
    check("busy_idle_gap", 32'(busy), 32'h0);
    @(posedge clk); #2;
    req = 1'b0;
    lat2 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); lat2++;
      if (done) break;
    end
    check("busy_second_lat", 32'(lat2), 32'd5);
    check("busy_first_ram",  {mem[16'h43], mem[16'h42], mem[16'h41], mem[16'h40]}, 32'h55667788);
    check("busy_second_ram", {mem[16'h83], mem[16'h82], mem[16'h81], mem[16'h80]}, 32'h0BADF00D);

    // Reset during the 3rd XFER cycle of a word store
    @(posedge clk); #2;
    req = 1'b1; wr = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h11223344;
    @(posedge clk); #2;
    req = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("rst_pre_we",   32'(ram_we),   32'h1);
    check("rst_pre_addr", 32'(ram_addr), 32'h22);
    #1 rst = 1'b1;
    #1;
    check("rst_ram_we",   32'(ram_we),   32'h0);
    check("rst_ram_sel",  32'(ram_sel),  32'h0);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_ram_d",    32'(ram_d),    32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    check("rst_done",     32'(done),     32'h0);
    check("rst_rdata",    rdata,         32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    check("rst_partial_ram", {mem[16'h23], mem[16'h22], mem[16'h21], mem[16'h20]}, 32'h00003344);
    ref_mem[16'h22] = 8'h00;
    ref_mem[16'h23] = 8'h00;
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, e);
    check("rst_after_lat",   32'(lat), 32'd5);
    check("rst_after_rdata", rdata,    32'h00003344);

    // Address bound and aliasing
    do_req(1'b1, 2'b10, 1'b0, 32'h3FC, 32'hCAFEBABE, lat, e);
    check("top_ram", {mem[16'h3FF], mem[16'h3FE], mem[16'h3FD], mem[16'h3FC]}, 32'hCAFEBABE);
    do_req(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, lat, e);
    check("top_rdata", rdata, 32'hCAFEBABE);
    do_req(1'b0, 2'b00, 1'b0, 32'h3FF, 32'h0, lat, e);
    check("top_byte_sx", rdata, 32'hFFFFFFCA);
    do_req(1'b1, 2'b00, 1'b0, 32'h400, 32'h0000005A, lat, e);
    check("alias_ram0", 32'(mem[0]), 32'h5A);
    do_req(1'b0, 2'b00, 1'b1, 32'h000, 32'h0, lat, e);
    check("alias_rdata", rdata, 32'h0000005A);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/byte_mem_sequencer.md
Name: byte_mem_sequencer

Overview:
- Initiator for a single byte-wide RAM bank with port set addr/d/we/q/sel, 8-bit data and combinational read.
- Turns one CPU load/store request (byte, half or word; little-endian) into a sequence of one-byte RAM cycles.
- On loads, assembles the bytes and sign- or zero-extends them to 32 bits.
- Sits between the CPU datapath and the byte RAM in the multi-cycle memory path.

Parameters:
- AW, 10, RAM address width in bits; byte addresses are taken modulo 2^AW.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  request strobe; sampled only in IDLE.
- wr  input  1  1 = store, 0 = load; latched on accept.
- size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal; latched on accept.
- uns  input  1  1 = zero-extend loads, 0 = sign-extend; latched on accept.
- addr  input  32  byte address; bits [AW-1:0] are used; latched on accept.
- wdata  input  32  store data, little-endian byte order; latched on accept.
- busy  output  1  high in XFER and DONE states.
- done  output  1  one-cycle completion pulse.
- err  output  1  misaligned or illegal request; valid while done=1.
- rdata  output  32  load result; valid from the done cycle and held until the next accept.
- ram_addr  output  AW  RAM byte address.
- ram_d  output  8  RAM write data.
- ram_we  output  1  RAM write enable.
- ram_sel  output  1  RAM select; the RAM writes only when ram_we and ram_sel are both 1.
- ram_q  input  8  RAM read data; combinational from ram_addr.

Behaviour:
- States: IDLE, XFER, DONE. Registers: base address, wr, uns, size, wdata, byte counter k (2 bits), last index n, read buffer, rdata, err.
- Reset (async, any state): state=IDLE, k=0, rdata=0, err=0, done=0, busy=0.
  - ram_we, ram_sel, ram_addr and ram_d are combinational from state, so they drop to 0 immediately.
  - A store interrupted by reset leaves already-written bytes written and the rest untouched.
- IDLE:
  - req=0: stay in IDLE.
  - req=1: latch all request inputs and set n = 0/1/3 for byte/half/word.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=11: go to DONE with err=1. No RAM cycle is issued and rdata is unchanged.
  - Otherwise: go to XFER with k=0 and err=0.
- XFER, cycle k:
  - ram_sel=1, ram_addr=(base+k) mod 2^AW, ram_d=wdata[8k+7:8k], ram_we=wr.
  - On a load, capture ram_q into buffer byte k at the clock edge.
  - If k==n go to DONE, otherwise k=k+1.
  - Data phase lasts n+1 cycles: 1, 2 or 4.
- DONE (exactly one cycle): done=1, busy=1.
  - On a load with err=0, rdata is written on the XFER→DONE edge:
    - byte: extend buffer[7:0] to 32 bits;
    - half: extend buffer[15:0];
    - word: buffer[31:0].
    - Extension uses the top bit of the loaded data when uns=0, zeros when uns=1.
  - On a store, rdata is unchanged.
  - Next state is always IDLE.
- Outside XFER: ram_sel=0, ram_we=0, ram_addr=0, ram_d=0.
- req while busy=1 is ignored; it is not queued. The earliest new accept is the cycle after DONE.
- Latency from accept edge to done: 2/3/5 cycles for byte/half/word; 1 cycle for error requests.
- Input changes after accept have no effect on the transfer in progress.

Test Plan:
- Word store then load: store addr=0x10, wdata=0xA1B2C3D4.
  - Expect RAM writes 0xD4, 0xC3, 0xB2, 0xA1 at 0x10 to 0x13 on four consecutive cycles, ram_sel=ram_we=1 throughout, done on the 5th cycle after accept.
  - Then word load at 0x10 → rdata=0xA1B2C3D4, err=0.
- Sign/zero extension: load byte at 0x13 with uns=0 → 0xFFFFFFA1; with uns=1 → 0x000000A1. Half load at 0x12 with uns=0 → 0xFFFFA1B2.
- Misaligned and illegal requests: word at 0x11, half at 0x13, and size=11 each give err=1 and done one cycle after accept, with ram_we=ram_sel=0 throughout and rdata holding its previous value.
- Busy protocol: hold req=1 continuously through a word store.
  - Exactly one transfer per IDLE visit; the second accept happens the cycle after done.
  - Changing wdata mid-transfer does not alter the RAM contents.
- Reset mid-store: assert rst during the 3rd XFER cycle of a word store of 0x11223344 at 0x20 (RAM preset to 0).
  - ram_we falls without waiting for a clock edge; the RAM holds 0x44, 0x33, 0x00, 0x00.
  - All outputs read 0 and state=IDLE.
- Address bound: word store then load at byte address 0x3FC with AW=10 round-trips correctly; addr=0x400 aliases to RAM address 0.
